buffer_drain: RTL and testbench

Read-side controller for the FIFO buffer stage. Pops words from a first-word-fall-through FIFO port and presents them as a valid/ready stream framed into fixed-length bursts, with `out_last` on the final beat of each burst. It holds a 2-entry output skid buffer, so `fifo_read_en` never depends combinationally on `out_ready`. It sits between the buffer stage and any downstream consumer.

---
 rtl/buffer_drain_if.sv | 24 ++
 rtl/buffer_drain.sv | 104 ++++++++++
 tb/tb_buffer_drain.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/buffer_drain_if.sv
// Handshake bundle for buffer_drain: FWFT FIFO read port on one side,
// valid/ready output stream on the other.
interface buffer_drain_if #(
  parameter int WIDTH = 16
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_read_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  // The drain controller sits on the slave side; the FIFO and consumer drive the master side.
  modport slave (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_read_en, out_valid, out_data, out_last
  );

  modport master (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_read_en, out_valid, out_data, out_last
  );
endinterface

// File: rtl/buffer_drain.sv
// Read-side drain controller: pops a FWFT FIFO in fixed-length bursts into a
// 2-entry skid buffer so the pop strobe never depends on out_ready.
module buffer_drain #(
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            drain_en,
  buffer_drain_if.slave   bus,
  output logic            busy,
  output logic            burst_done
);

  localparam int CNT_W = $clog2(BURST_LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } entry_t;

  state_e           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  entry_t           ent0_q, ent0_d;
  entry_t           ent1_q, ent1_d;

  logic   pop;
  logic   hs;
  logic   pop_last;
  entry_t new_ent;

  // Pop depends only on registered state and the FIFO flag, never on out_ready.
  assign pop      = (state_q == BURST) && !bus.fifo_empty && (occ_q < 2'd2);
  assign pop_last = pop && (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign hs       = bus.out_valid && bus.out_ready;
  assign new_ent  = '{data: bus.fifo_data, last: pop_last};

  assign bus.fifo_read_en = pop;
  assign bus.out_valid    = (occ_q != 2'd0);
  assign bus.out_data     = ent0_q.data;
  assign bus.out_last     = bus.out_valid && ent0_q.last;
  assign burst_done       = hs && ent0_q.last;
  assign busy             = (state_q != IDLE) || (occ_q != 2'd0);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE:  if (drain_en && !bus.fifo_empty) state_d = BURST;
      BURST: if (pop_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pop) begin
      beat_cnt_d = pop_last ? '0 : beat_cnt_q + CNT_W'(1);
    end
  end

  // Skid buffer: in-order, entry 0 is the head; entry 1 shifts forward on handshake.
  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    unique case ({pop, hs})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) ent0_d = new_ent;
        else               ent1_d = new_ent;
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        ent0_d = ent1_q;
      end
      // A pop only happens with occ < 2 and a handshake needs occ > 0, so occ is 1 here.
      2'b11:   ent0_d = new_ent;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the skid data is reset too, since out_data must read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      beat_cnt_q <= '0;
      ent0_q     <= '0;
      ent1_q     <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      beat_cnt_q <= beat_cnt_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
    end
  end

endmodule

// File: tb/tb_buffer_drain.sv
// Self-checking bench for buffer_drain: queue-based FIFO and skid model,
// directed scenarios followed by randomized traffic.
module tb_buffer_drain;

  localparam int WIDTH     = 16;
  localparam int BURST_LEN = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic drain_en;
  logic busy;
  logic burst_done;

  buffer_drain_if #(.WIDTH(WIDTH)) bus ();

  buffer_drain #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .drain_en   (drain_en),
    .bus        (bus),
    .busy       (busy),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents, skid contents, burst progress as plain counts.
  logic [WIDTH-1:0] fq[$];
  beat_t            skid[$];
  bit               m_burst;
  int               m_beats;
  int               n_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    skid.delete();
    m_burst = 0;
    m_beats = 0;
  endtask

  // One clock: drive inputs at negedge, compare outputs, advance model at posedge.
  task automatic step(input logic drain, input logic ready);
    bit    e_pop, e_valid, e_hs, e_done, e_busy;
    beat_t head;
    @(negedge clk);
    drain_en       = drain;
    bus.out_ready  = ready;
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    #1;
    if (!rst_n) begin
      check("rst_read_en", 32'(bus.fifo_read_en), 32'd0);
      check("rst_valid",   32'(bus.out_valid),    32'd0);
      check("rst_last",    32'(bus.out_last),     32'd0);
      check("rst_done",    32'(burst_done),       32'd0);
      check("rst_busy",    32'(busy),             32'd0);
      check("rst_data",    32'(bus.out_data),     32'd0);
      @(posedge clk);
      return;
    end
    e_valid = (skid.size() != 0);
    head    = e_valid ? skid[0] : '0;
    e_pop   = m_burst && (fq.size() != 0) && (skid.size() < 2);
    e_hs    = e_valid && ready;
    e_done  = e_hs && head.last;
    e_busy  = m_burst || e_valid;
    check("read_en",    32'(bus.fifo_read_en), 32'(e_pop));
    check("out_valid",  32'(bus.out_valid),    32'(e_valid));
    check("busy",       32'(busy),             32'(e_busy));
    check("burst_done", 32'(burst_done),       32'(e_done));
    check("out_last",   32'(bus.out_last),     32'(e_valid && head.last));
    if (e_valid) check("out_data", 32'(bus.out_data), 32'(head.data));
    @(posedge clk);
    if (e_done) n_done++;
    if (e_hs) void'(skid.pop_front());
    if (!m_burst) begin
      if (drain && fq.size() != 0) m_burst = 1;
    end else if (e_pop) begin
      skid.push_back('{data: fq.pop_front(), last: (m_beats == BURST_LEN - 1)});
      m_beats++;
      if (m_beats == BURST_LEN) begin
        m_beats = 0;
        m_burst = 0;
      end
    end
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) fq.push_back(WIDTH'(base + i));
  endtask

  initial begin
    int done_before;
    rst_n          = 1'b0;
    drain_en       = 1'b0;
    bus.out_ready  = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    model_reset();
    n_done = 0;

    // Reset with a loaded FIFO and drain requested: everything stays 0.
    load(4, 16'h00A0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    fq.delete();

    // Single burst 1..4 with a one-cycle drain pulse.
    load(4, 16'h0001);
    done_before = n_done;
    step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    check("single_done_count", 32'(n_done - done_before), 32'd1);
    check("single_fifo_left",  32'(fq.size()),            32'd0);

    // Backpressure with 8 words, then release.
    load(8, 16'h0100);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    check("bp_fifo_left", 32'(fq.size()), 32'd6);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
    check("bp_fifo_empty", 32'(fq.size()), 32'd0);
    step(1'b0, 1'b1);

    // Mid-burst underflow: 2 words, a 5-cycle gap, then 2 more.
    load(2, 16'h0200);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    load(2, 16'h0202);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);

    // drain_en dropped after the first pop: burst completes, 2 words remain.
    load(6, 16'h0300);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    check("dis_fifo_left", 32'(fq.size()), 32'd2);
    fq.delete();

    // Async reset with the skid full mid-burst.
    load(8, 16'h0400);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(bus.out_valid), 32'd0);
    check("async_busy",  32'(busy),          32'd0);
    model_reset();
    step(1'b1, 1'b1);
    #2 rst_n = 1'b1;
    done_before = n_done;
    step(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("async_burst_done", 32'(n_done - done_before), 32'd1);
    fq.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

    // Randomized traffic with varying pressure.
    for (int ph = 0; ph < 4; ph++) begin
      int p_push  = (ph == 0) ? 90 : (ph == 1) ? 30 : 60;
      int p_ready = (ph == 2) ? 25 : (ph == 1) ? 90 : 60;
      int p_drain = (ph == 3) ? 40 : 85;
      for (int c = 0; c < 400; c++) begin
        if (fq.size() < 12 && ($urandom % 100) < p_push) fq.push_back(WIDTH'($urandom));
        step(($urandom % 100) < p_drain, ($urandom % 100) < p_ready);
      end
    end
    // Flush whatever remains in the skid.
    fq.delete();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    check("final_skid_empty", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
